// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_arb_pkg
//  Description : Shared types, default widths and the round-robin pick helper
//                for the APB master arbiter.
//  Contents    : arb_state_e  - arbiter phase (IDLE / SETUP / ACCESS)
//                rr_pick()    - first requester at or after a pointer, wrapping
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    localparam int c_DEF_MASTER_COUNT   = 4;
    localparam int c_DEF_ADDR_WIDTH     = 32;
    localparam int c_DEF_DATA_WIDTH     = 32;
    localparam int c_DEF_TIMEOUT_CYCLES = 256;

    // rr_pick works on a fixed-width request vector; callers zero-extend.
    localparam int c_MAX_MASTERS = 32;
    localparam int c_MAX_IDX_W   = 5;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        SETUP  = c_ST_SETUP,
        ACCESS = c_ST_ACCESS
    } arb_state_e;

    // Returns the first set bit of req searching ptr, ptr+1, ... modulo count.
    // Walking offsets from high to low lets the smallest offset win last.
    // With no request set the result is ptr (callers qualify with |req).
    function automatic int unsigned rr_pick(
        input logic [c_MAX_MASTERS-1:0] req,
        input int unsigned              ptr,
        input int unsigned              count
    );
        int unsigned idx;
        int unsigned pick;
        pick = ptr;
        for (int off = c_MAX_MASTERS - 1; off >= 0; off--) begin
            if (unsigned'(off) < count) begin
                idx = ptr + unsigned'(off);
                if (idx >= count) begin
                    idx = idx - count;
                end
                if (req[idx[c_MAX_IDX_W-1:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : apb_rr_picker
//  Description : Combinational round-robin priority select.
//  Ports       : i_req   - request vector (N bits)
//                i_ptr   - index with highest priority this round
//                o_valid - at least one request present
//                o_index - selected requester
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_rr_picker
    import apb_arb_pkg::*;
#(
    parameter int N    = c_DEF_MASTER_COUNT,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic            o_valid,
    output logic [IDXW-1:0] o_index
);

    logic [c_MAX_MASTERS-1:0] w_req_ext;

    always_comb begin
        w_req_ext        = '0;
        w_req_ext[N-1:0] = i_req;
    end

    assign o_valid = |i_req;
    assign o_index = IDXW'(rr_pick(w_req_ext, 32'(i_ptr), unsigned'(N)));

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : apb_master_arbiter
//  Description : Round-robin arbiter sharing one downstream APB bus among
//                APB_MASTER_COUNT masters. The SETUP/ACCESS phases are
//                regenerated locally; losing masters see pready low.
//  Ports       : clk_i, rst_i (sync, active high)
//                m_*_i / m_*_o  - per-master APB request / response
//                p*_o / p*_i    - downstream APB bus
//                grant_idx_o    - current/last granted master
//                busy_o         - a transfer is in flight
//  Option      : APB_ARB_TIMEOUT_EN - abort an ACCESS phase after
//                TIMEOUT_CYCLES cycles without pready_i, answering with error
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int APB_MASTER_COUNT = c_DEF_MASTER_COUNT,
    parameter int APB_ADDR_WIDTH   = c_DEF_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH   = c_DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES   = c_DEF_TIMEOUT_CYCLES,
    localparam int c_IDXW = (APB_MASTER_COUNT > 1) ? $clog2(APB_MASTER_COUNT) : 1
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic [APB_MASTER_COUNT-1:0]                    m_psel_i,
    input  logic [APB_MASTER_COUNT-1:0][APB_ADDR_WIDTH-1:0] m_paddr_i,
    input  logic [APB_MASTER_COUNT-1:0]                    m_pwrite_i,
    input  logic [APB_MASTER_COUNT-1:0]                    m_penable_i,
    input  logic [APB_MASTER_COUNT-1:0][APB_DATA_WIDTH-1:0] m_pwdata_i,
    output logic [APB_MASTER_COUNT-1:0][APB_DATA_WIDTH-1:0] m_prdata_o,
    output logic [APB_MASTER_COUNT-1:0]                    m_pready_o,
    output logic [APB_MASTER_COUNT-1:0]                    m_pslverr_o,
    output logic                                           psel_o,
    output logic [APB_ADDR_WIDTH-1:0]                      paddr_o,
    output logic                                           pwrite_o,
    output logic                                           penable_o,
    output logic [APB_DATA_WIDTH-1:0]                      pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]                      prdata_i,
    input  logic                                           pready_i,
    input  logic                                           pslverr_i,
    output logic [c_IDXW-1:0]                              grant_idx_o,
    output logic                                           busy_o
);

    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(APB_MASTER_COUNT - 1);

    arb_state_e        r_state;
    logic [c_IDXW-1:0] r_grant;
    logic [c_IDXW-1:0] r_rr_ptr;

    logic              w_pick_valid;
    logic [c_IDXW-1:0] w_pick_idx;
    logic [c_IDXW-1:0] w_next_ptr;
    logic              w_timeout;
    logic              w_finish;

    // Master-side penable carries no information here: phases are regenerated.
    logic              w_unused_penable;
    assign w_unused_penable = ^m_penable_i;

    apb_rr_picker #(
        .N    (APB_MASTER_COUNT),
        .IDXW (c_IDXW)
    ) u_picker (
        .i_req   (m_psel_i),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_index (w_pick_idx)
    );

    assign w_next_ptr = (r_grant == c_LAST_IDX) ? '0 : r_grant + c_IDXW'(1);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Fires on the TIMEOUT_CYCLES-th ACCESS cycle still lacking pready_i.
    assign w_timeout = (r_state == ACCESS) && !pready_i
                       && (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ACCESS) && !pready_i) begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_finish = (r_state == ACCESS) && (pready_i || w_timeout);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (w_finish) begin
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign psel_o      = (r_state != IDLE);
    assign penable_o   = (r_state == ACCESS);
    assign busy_o      = (r_state != IDLE);
    assign grant_idx_o = r_grant;

    always_comb begin
        paddr_o  = '0;
        pwrite_o = 1'b0;
        pwdata_o = '0;
        if (r_state != IDLE) begin
            paddr_o  = m_paddr_i[r_grant];
            pwrite_o = m_pwrite_i[r_grant];
            pwdata_o = m_pwdata_i[r_grant];
        end
    end

    // A granted master that dropped its request gets no response; the
    // downstream transfer still completes so the slave stays protocol-clean.
    always_comb begin
        m_pready_o  = '0;
        m_pslverr_o = '0;
        m_prdata_o  = '0;
        if (w_finish && m_psel_i[r_grant]) begin
            m_pready_o[r_grant] = 1'b1;
            if (w_timeout) begin
                m_pslverr_o[r_grant] = 1'b1;
            end else begin
                m_pslverr_o[r_grant] = pslverr_i;
                m_prdata_o[r_grant]  = prdata_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_master_arbiter
//  Description : Self-checking bench for apb_master_arbiter (4 masters).
//                Directed phase/latency, error, reset and dropped-request
//                cases, then randomized request patterns against a
//                round-robin reference model. Timeout case active when
//                APB_ARB_TIMEOUT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

    localparam int M  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int c_TMO = 4;
`ifdef APB_ARB_TIMEOUT_EN
    localparam int c_T3_STALL = 3;
`else
    localparam int c_T3_STALL = 5;
`endif

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    logic [M-1:0]          m_psel_i;
    logic [M-1:0][AW-1:0]  m_paddr_i;
    logic [M-1:0]          m_pwrite_i;
    logic [M-1:0]          m_penable_i;
    logic [M-1:0][DW-1:0]  m_pwdata_i;
    logic [M-1:0][DW-1:0]  m_prdata_o;
    logic [M-1:0]          m_pready_o;
    logic [M-1:0]          m_pslverr_o;
    logic                  psel_o;
    logic [AW-1:0]         paddr_o;
    logic                  pwrite_o;
    logic                  penable_o;
    logic [DW-1:0]         pwdata_o;
    logic [DW-1:0]         prdata_i;
    logic                  pready_i;
    logic                  pslverr_i;
    logic [1:0]            grant_idx_o;
    logic                  busy_o;

    apb_master_arbiter #(
        .APB_MASTER_COUNT (M),
        .APB_ADDR_WIDTH   (AW),
        .APB_DATA_WIDTH   (DW),
        .TIMEOUT_CYCLES   (c_TMO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .m_psel_i    (m_psel_i),
        .m_paddr_i   (m_paddr_i),
        .m_pwrite_i  (m_pwrite_i),
        .m_penable_i (m_penable_i),
        .m_pwdata_i  (m_pwdata_i),
        .m_prdata_o  (m_prdata_o),
        .m_pready_o  (m_pready_o),
        .m_pslverr_o (m_pslverr_o),
        .psel_o      (psel_o),
        .paddr_o     (paddr_o),
        .pwrite_o    (pwrite_o),
        .penable_o   (penable_o),
        .pwdata_o    (pwdata_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .grant_idx_o (grant_idx_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int ptr_m = 0;   // reference round-robin pointer

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: first requester found walking ptr, ptr+1, ... modulo M.
    function automatic int winner(input logic [M-1:0] req, input int ptr);
        for (int k = 0; k < M; k++) begin
            if (req[(ptr + k) % M]) return (ptr + k) % M;
        end
        return -1;
    endfunction

    task automatic randomize_payload();
        for (int i = 0; i < M; i++) begin
            m_paddr_i[i]  = $urandom;
            m_pwdata_i[i] = $urandom;
            m_pwrite_i[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic check_resp(input int idx, input bit valid, input logic [DW-1:0] rdata, input bit err);
        for (int i = 0; i < M; i++) begin
            bit hit;
            hit = valid && (i == idx);
            check($sformatf("pready[%0d]", i), m_pready_o[i], hit);
            check($sformatf("pslverr[%0d]", i), m_pslverr_o[i], hit && err);
            check($sformatf("prdata[%0d]", i), m_prdata_o[i], hit ? rdata : '0);
        end
    endtask

    task automatic do_reset();
        rst_i     = 1'b1;
        m_psel_i  = '0;
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        ptr_m = 0;
    endtask

    // Called in an IDLE cycle with requests already driven.
    task automatic run_xfer(input int exp, input int stalls, input logic [DW-1:0] rdata,
                            input bit err, input bit drop);
        check("idle_busy", busy_o, 0);
        check("idle_psel", psel_o, 0);
        check("idle_paddr", paddr_o, 0);
        step();
        check("setup_psel", psel_o, 1);
        check("setup_penable", penable_o, 0);
        check("setup_grant", grant_idx_o, exp);
        check("setup_paddr", paddr_o, m_paddr_i[exp]);
        check("setup_pwrite", pwrite_o, m_pwrite_i[exp]);
        check("setup_pwdata", pwdata_o, m_pwdata_i[exp]);
        check("setup_pready", m_pready_o, 0);
        step();
        if (drop) m_psel_i[exp] = 1'b0;
        for (int s = 0; s < stalls; s++) begin
            pready_i = 1'b0;
            prdata_i = $urandom;
            #1;
            check("wait_penable", penable_o, 1);
            check("wait_pready", m_pready_o, 0);
            step();
        end
        pready_i  = 1'b1;
        prdata_i  = rdata;
        pslverr_i = err;
        #1;
        check("access_penable", penable_o, 1);
        check_resp(exp, !drop, rdata, err);
        step();
        pready_i  = 1'b0;
        pslverr_i = 1'b0;
        ptr_m = (exp + 1) % M;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [M-1:0] mask;
        int w;

        m_penable_i = '0;
        prdata_i    = '0;
        randomize_payload();
        do_reset();

        // Reset state
        check("rst_psel", psel_o, 0);
        check("rst_penable", penable_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_grant", grant_idx_o, 0);
        check_resp(0, 0, '0, 0);

        // m1 writes 0x10 / 0xAA, immediate pready
        m_paddr_i[1]  = 32'h10;
        m_pwdata_i[1] = 32'hAA;
        m_pwrite_i[1] = 1'b1;
        m_psel_i      = 4'b0010;
        run_xfer(1, 0, 32'h5555_0001, 0, 0);

        // m2 read with slave wait states
        m_psel_i      = 4'b0100;
        m_pwrite_i[2] = 1'b0;
        run_xfer(2, c_T3_STALL, 32'h1234, 0, 0);

        // slave error on m0
        m_psel_i = 4'b0001;
        run_xfer(0, 0, 32'hCAFE, 1, 0);

        // reset in ACCESS of m3 (pointer is 1 beforehand)
        m_psel_i = 4'b1000;
        step();
        check("m3_grant", grant_idx_o, 3);
        step();
        check("m3_access", penable_o, 1);
        rst_i = 1'b1;
        step();
        check("rstmid_psel", psel_o, 0);
        check("rstmid_penable", penable_o, 0);
        check("rstmid_busy", busy_o, 0);
        rst_i    = 1'b0;
        ptr_m    = 0;
        m_psel_i = 4'b0101;
        run_xfer(winner(4'b0101, ptr_m), 0, 32'h77, 0, 0);

        // all four requesting continuously from pointer 0
        do_reset();
        m_psel_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            randomize_payload();
            run_xfer(k % M, 0, $urandom, 0, 0);
        end

`ifdef APB_ARB_TIMEOUT_EN
        // slave never answers
        m_psel_i = 4'b0001;
        w = winner(m_psel_i, ptr_m);
        step();
        step();
        for (int k = 0; k < c_TMO - 1; k++) begin
            pready_i = 1'b0;
            #1;
            check("tmo_wait", m_pready_o, 0);
            step();
        end
        prdata_i = 32'hDEAD_BEEF;
        #1;
        check_resp(w, 1, '0, 1);
        step();
        check("tmo_psel_drop", psel_o, 0);
        check("tmo_busy", busy_o, 0);
        ptr_m = (w + 1) % M;
`endif

        // granted master drops request mid-transfer: response discarded
        m_psel_i = 4'b0010;
        run_xfer(winner(4'b0010, ptr_m), 1, 32'hBEEF, 1, 1);

        // randomized requests against the reference pointer
        do_reset();
        mask = M'($urandom_range(1, (1 << M) - 1));
        for (int n = 0; n < 40; n++) begin
            randomize_payload();
            m_psel_i = mask;
            w = winner(mask, ptr_m);
            run_xfer(w, $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), 0);
            mask[w] = 1'b0;
            mask = mask | M'($urandom_range(0, (1 << M) - 1));
            if (mask == '0) mask = M'($urandom_range(1, (1 << M) - 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
